// File: rtl/m_ai_move_scheduler_pkg.sv
// Shared constants and helpers for the Connect-Four AI move scheduler.
// Board geometry and evaluator widths used by the scheduler and its evaluator bus.
package m_ai_move_scheduler_pkg;

  localparam int unsigned COL_COUNT             = 7;
  localparam int unsigned ROW_COUNT             = 6;
  localparam int unsigned PILE_CNT_W            = 3;
  localparam int unsigned SCORE_W               = 8;
  localparam int unsigned COL_SIZE              = 3;
  localparam int unsigned FIELD_SIZE            = COL_COUNT * ROW_COUNT;
  localparam int unsigned PILE_COUNT_ARRAY_SIZE = COL_COUNT * PILE_CNT_W;

  typedef logic signed [SCORE_W-1:0] score_t;

  // Distance of a column from the board centre, used to break score ties.
  function automatic logic [COL_SIZE-1:0] centre_dist(input logic [COL_SIZE-1:0] col,
                                                      input logic [COL_SIZE-1:0] centre);
    return (col >= centre) ? (col - centre) : (centre - col);
  endfunction

endpackage

// File: rtl/m_ai_move_scheduler_if.sv
// Request/response bus between the move scheduler and the shared evaluator.
// Signal names keep the legacy port names so the evaluator wiring is unchanged.
interface m_ai_move_scheduler_if;
  import m_ai_move_scheduler_pkg::*;

  logic                  o_eval_req;
  logic [COL_SIZE-1:0]   o_eval_col;
  logic [FIELD_SIZE-1:0] o_me_field;
  logic [FIELD_SIZE-1:0] o_op_field;
  logic                  i_eval_ack;
  score_t                i_eval_score;

  modport master (
    output o_eval_req, o_eval_col, o_me_field, o_op_field,
    input  i_eval_ack, i_eval_score
  );

  modport slave (
    input  o_eval_req, o_eval_col, o_me_field, o_op_field,
    output i_eval_ack, i_eval_score
  );

endinterface

// File: rtl/m_next_legal_col.sv
// Combinational search for the lowest non-full column at or above a start index.
module m_next_legal_col #(
  parameter int unsigned COL_COUNT = 7,
  parameter int unsigned ROW_COUNT = 6,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned COL_W     = 3,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [COL_COUNT*CNT_W-1:0] counts_i,
  input  logic [IDX_W-1:0]           idx_i,
  output logic                       found_o,
  output logic [COL_W-1:0]           col_o
);

  always_comb begin
    found_o = 1'b0;
    col_o   = '0;
    for (int unsigned c = 0; c < COL_COUNT; c++) begin
      if (!found_o &&
          (counts_i[c*CNT_W +: CNT_W] < CNT_W'(ROW_COUNT)) &&
          (IDX_W'(c) >= idx_i)) begin
        found_o = 1'b1;
        col_o   = COL_W'(c);
      end
    end
  end

endmodule

// File: rtl/m_ai_move_scheduler.sv
// Walks every legal column of a board snapshot through the shared evaluator
// and reports the best-scoring column (centre-most on ties), or "no move".
module m_ai_move_scheduler #(
  parameter int unsigned COL_COUNT = 7,
  parameter int unsigned ROW_COUNT = 6,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                           w_clk,
  input  logic                           w_rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [COL_COUNT*ROW_COUNT-1:0] i_me_field,
  input  logic [COL_COUNT*ROW_COUNT-1:0] i_op_field,
  input  logic [COL_COUNT*CNT_W-1:0]     i_pile_count_array,
  m_ai_move_scheduler_if.master          ev,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [$clog2(COL_COUNT)-1:0]   o_col,
  output logic                           o_no_move,
  output logic                           o_timeout
);
  import m_ai_move_scheduler_pkg::*;

  localparam int unsigned COL_W  = $clog2(COL_COUNT);
  localparam int unsigned IDX_W  = $clog2(COL_COUNT + 1);
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned FLD_W  = COL_COUNT * ROW_COUNT;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [COL_W-1:0]          CENTRE    = COL_W'(COL_COUNT / 2);

  logic [2:0]                 state_q, state_d;
  logic [FLD_W-1:0]           me_q, me_d, op_q, op_d;
  logic [COL_COUNT*CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic                       req_q, req_d;
  logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
  logic                       best_valid_q, best_valid_d;
  logic signed [SCORE_W-1:0]  best_score_q, best_score_d;
  logic [COL_W-1:0]           best_col_q, best_col_d;
  logic [COL_W-1:0]           res_col_q, res_col_d;
  logic                       no_move_q, no_move_d;
  logic                       timeout_q, timeout_d;

  logic                       nl_found;
  logic [COL_W-1:0]           nl_col;
  logic                       wait_expired;
  logic signed [SCORE_W-1:0]  cand_score;
  logic [COL_W-1:0]           cand_dist, best_dist;
  logic                       cand_better;

  m_next_legal_col #(
    .COL_COUNT (COL_COUNT),
    .ROW_COUNT (ROW_COUNT),
    .CNT_W     (CNT_W),
    .COL_W     (COL_W),
    .IDX_W     (IDX_W)
  ) u_next_legal_col (
    .counts_i (cnt_q),
    .idx_i    (idx_q),
    .found_o  (nl_found),
    .col_o    (nl_col)
  );

  // A timed-out column competes with the most negative score so it is only
  // chosen when nothing better exists.
  assign wait_expired = (wcnt_q == WCNT_W'(TIMEOUT - 1));
  assign cand_score   = ev.i_eval_ack ? ev.i_eval_score : SCORE_MIN;
  assign cand_dist    = centre_dist(col_q, CENTRE);
  assign best_dist    = centre_dist(best_col_q, CENTRE);
  assign cand_better  = !best_valid_q
                     || (cand_score > best_score_q)
                     || ((cand_score == best_score_q) &&
                         ((cand_dist < best_dist) ||
                          ((cand_dist == best_dist) && (col_q < best_col_q))));

  always_comb begin
    state_d      = state_q;
    me_d         = me_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    col_d        = col_q;
    req_d        = req_q;
    wcnt_d       = wcnt_q;
    best_valid_d = best_valid_q;
    best_score_d = best_score_q;
    best_col_d   = best_col_q;
    res_col_d    = res_col_q;
    no_move_d    = no_move_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          me_d         = i_me_field;
          op_d         = i_op_field;
          cnt_d        = i_pile_count_array;
          idx_d        = '0;
          timeout_d    = 1'b0;
          best_valid_d = 1'b0;
          best_score_d = '0;
          best_col_d   = '0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        if (nl_found) begin
          col_d   = nl_col;
          state_d = S_REQ;
        end else begin
          res_col_d = best_valid_q ? best_col_q : '0;
          no_move_d = !best_valid_q;
          state_d   = S_DONE;
        end
      end
      S_REQ: begin
        req_d   = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (ev.i_eval_ack || wait_expired) begin
          req_d = 1'b0;
          if (!ev.i_eval_ack) begin
            timeout_d = 1'b1;
          end
          if (cand_better) begin
            best_valid_d = 1'b1;
            best_score_d = cand_score;
            best_col_d   = col_q;
          end
          idx_d   = IDX_W'(col_q) + IDX_W'(1);
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the active state decided, including a same-cycle ack.
    if (i_abort && (state_q != S_IDLE)) begin
      req_d   = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q      <= S_IDLE;
      me_q         <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      col_q        <= '0;
      req_q        <= 1'b0;
      wcnt_q       <= '0;
      best_valid_q <= 1'b0;
      best_score_q <= '0;
      best_col_q   <= '0;
      res_col_q    <= '0;
      no_move_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      me_q         <= me_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      req_q        <= req_d;
      wcnt_q       <= wcnt_d;
      best_valid_q <= best_valid_d;
      best_score_q <= best_score_d;
      best_col_q   <= best_col_d;
      res_col_q    <= res_col_d;
      no_move_q    <= no_move_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ev.o_eval_req = req_q;
  assign ev.o_eval_col = col_q;
  assign ev.o_me_field = me_q;
  assign ev.o_op_field = op_q;

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_col     = res_col_q;
  assign o_no_move = no_move_q;
  assign o_timeout = timeout_q;

endmodule
